dsigmf: RTL and testbench

Sequential sigmoid-derivative and error-gradient unit for the LSTM backward pass. Takes a forward-pass sigmoid activation `s` and an incoming error gradient `err`, both in the signed fixed-point format of the forward sigmoid block. It produces `dsig = s*(1-s)` and `delta = err*dsig`. It sits at the gate-delta stage of the backprop datapath, consuming stored forward activations, and time-shares one signed multiplier under a small FSM with valid/ready handshakes on both sides.

---
 rtl/dsigmf_if.sv | 24 ++
 rtl/dsigmf.sv | 95 +++++++++
 tb/tb_dsigmf.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dsigmf_if.sv
// Handshake bundle for the sigmoid-derivative / gate-delta unit.
// Upstream drives i_* and o_ready; the unit drives i_ready and o_*.
interface dsigmf_if #(
    parameter int WIDTH = 24
);
    logic                    i_valid;
    logic                    i_ready;
    logic signed [WIDTH-1:0] i_s;
    logic signed [WIDTH-1:0] i_err;
    logic                    o_valid;
    logic                    o_ready;
    logic signed [WIDTH-1:0] o_dsig;
    logic signed [WIDTH-1:0] o_delta;

    modport master (
        output i_valid, i_s, i_err, o_ready,
        input  i_ready, o_valid, o_dsig, o_delta
    );

    modport slave (
        input  i_valid, i_s, i_err, o_ready,
        output i_ready, o_valid, o_dsig, o_delta
    );
endinterface

// File: rtl/dsigmf.sv
// Sigmoid derivative s*(1-s) and gate delta err*s*(1-s) in Q4.20, sharing one
// signed multiplier across two FSM states.
module dsigmf #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 20
) (
    input  logic     clk,
    input  logic     rst,
    dsigmf_if.slave  bus
);
    localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL_D, MUL_E, DONE} state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0]   s_p0, one_m_s_p0, err_p0;
    logic signed [WIDTH-1:0]   dsig_p1;
    logic signed [WIDTH-1:0]   delta_p2;
    logic                      vld_p2;
    logic signed [WIDTH-1:0]   s_clamped;
    logic signed [WIDTH-1:0]   mul_a, mul_b;
    logic signed [2*WIDTH-1:0] prod;

    // Activations outside [0, 1.0] come from rounding in the forward block.
    function automatic logic signed [WIDTH-1:0] clamp_s(input logic signed [WIDTH-1:0] s);
        if (s[WIDTH-1])
            return '0;
        else if (s > ONE)
            return ONE;
        else
            return s;
    endfunction

    // Keeps bits [FRAC+WIDTH-1:FRAC]: floor toward -inf, no saturation needed.
    function automatic logic signed [WIDTH-1:0] renorm(input logic signed [2*WIDTH-1:0] p);
        return p[FRAC+WIDTH-1:FRAC];
    endfunction

    assign s_clamped = clamp_s(bus.i_s);
    assign prod      = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);

    always_comb begin
        state_nxt = state;
        mul_a     = s_p0;
        mul_b     = one_m_s_p0;
        case (state)
            IDLE:  if (bus.i_valid) state_nxt = MUL_D;
            MUL_D: state_nxt = MUL_E;
            MUL_E: begin
                mul_a     = err_p0;
                mul_b     = dsig_p1;
                state_nxt = DONE;
            end
            DONE:  if (bus.o_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s_p0       <= '0;
            one_m_s_p0 <= '0;
            err_p0     <= '0;
            dsig_p1    <= '0;
            delta_p2   <= '0;
            vld_p2     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                // p0: capture clamped operands on accept
                IDLE: if (bus.i_valid) begin
                    s_p0       <= s_clamped;
                    one_m_s_p0 <= ONE - s_clamped;
                    err_p0     <= bus.i_err;
                end
                // p1: dsig = s*(1-s)
                MUL_D: dsig_p1 <= renorm(prod);
                // p2: delta = err*dsig, result presented downstream
                MUL_E: begin
                    delta_p2 <= renorm(prod);
                    vld_p2   <= 1'b1;
                end
                DONE: if (bus.o_ready) vld_p2 <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.i_ready = (state == IDLE) && !rst;
    assign bus.o_valid = vld_p2;
    assign bus.o_dsig  = dsig_p1;
    assign bus.o_delta = delta_p2;
endmodule

// File: tb/tb_dsigmf.sv
// Directed and randomized bench for dsigmf against an arithmetic reference model.
module tb_dsigmf;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    logic [W-1:0] prev_d = '0;
    logic [W-1:0] prev_e = '0;

    dsigmf_if #(.WIDTH(W)) ifc ();

    dsigmf #(.WIDTH(W), .FRAC(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: real-valued rules evaluated with 64-bit integers, floor on rescale.
    function automatic logic [W-1:0] ref_dsig(input logic [W-1:0] s);
        longint sv;
        sv = longint'($signed(s));
        if (sv < 0) sv = 0;
        if (sv > 1048576) sv = 1048576;
        return W'((sv * (1048576 - sv)) >>> 20);
    endfunction

    function automatic logic [W-1:0] ref_delta(input logic [W-1:0] s, input logic [W-1:0] err);
        longint e, d;
        e = longint'($signed(err));
        d = longint'($signed(ref_dsig(s)));
        return W'((e * d) >>> 20);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] err,
                         input logic [W-1:0] exp_d, input logic [W-1:0] exp_e,
                         input bit hold_rdy, input int bp_cycles);
        chk("ready_idle", W'(ifc.i_ready), W'(1));
        ifc.i_valid = 1'b1;
        ifc.i_s     = s;
        ifc.i_err   = err;
        ifc.o_ready = hold_rdy;
        step();
        ifc.i_valid = 1'b0;
        chk("muld_vld", W'(ifc.o_valid), W'(0));
        chk("muld_ird", W'(ifc.i_ready), W'(0));
        chk("muld_dsig_hold", ifc.o_dsig, prev_d);
        step();
        chk("mule_dsig", ifc.o_dsig, exp_d);
        chk("mule_delta_hold", ifc.o_delta, prev_e);
        chk("mule_vld", W'(ifc.o_valid), W'(0));
        step();
        chk("done_vld", W'(ifc.o_valid), W'(1));
        chk("done_dsig", ifc.o_dsig, exp_d);
        chk("done_delta", ifc.o_delta, exp_e);
        if (bp_cycles > 0) begin
            ifc.o_ready = 1'b0;
            ifc.i_valid = 1'b1;
            ifc.i_s     = W'($urandom);
            ifc.i_err   = W'($urandom);
            for (int i = 0; i < bp_cycles; i++) begin
                step();
                chk("bp_vld", W'(ifc.o_valid), W'(1));
                chk("bp_dsig", ifc.o_dsig, exp_d);
                chk("bp_delta", ifc.o_delta, exp_e);
                chk("bp_ird", W'(ifc.i_ready), W'(0));
            end
            ifc.i_valid = 1'b0;
        end
        ifc.o_ready = 1'b1;
        step();
        ifc.o_ready = 1'b0;
        chk("hs_vld", W'(ifc.o_valid), W'(0));
        chk("hs_ird", W'(ifc.i_ready), W'(1));
        chk("hs_dsig_stable", ifc.o_dsig, exp_d);
        chk("hs_delta_stable", ifc.o_delta, exp_e);
        prev_d = exp_d;
        prev_e = exp_e;
    endtask

    initial begin
        logic [W-1:0] rs, re;
        rst         = 1'b1;
        ifc.i_valid = 1'b0;
        ifc.i_s     = '0;
        ifc.i_err   = '0;
        ifc.o_ready = 1'b0;
        step();
        ifc.i_valid = 1'b1;
        step();
        chk("rst_ird", W'(ifc.i_ready), W'(0));
        chk("rst_vld", W'(ifc.o_valid), W'(0));
        chk("rst_dsig", ifc.o_dsig, W'(0));
        chk("rst_delta", ifc.o_delta, W'(0));
        rst         = 1'b0;
        ifc.i_valid = 1'b0;
        #1;

        // Directed vectors with hand-derived results
        do_op(24'h080000, 24'h100000, 24'h040000, 24'h040000, 1'b0, 0);
        do_op(24'h080000, 24'hF00000, 24'h040000, 24'hFC0000, 1'b1, 0);
        do_op(24'h099999, 24'h100000, 24'h03D70A, 24'h03D70A, 1'b0, 0);
        do_op(24'h000000, 24'h100000, 24'h000000, 24'h000000, 1'b0, 0);
        do_op(24'hFFFFF0, 24'h100000, 24'h000000, 24'h000000, 1'b0, 0);
        do_op(24'h120000, 24'h100000, 24'h000000, 24'h000000, 1'b0, 0);
        do_op(24'h040000, 24'h7FFFFF, ref_dsig(24'h040000), ref_delta(24'h040000, 24'h7FFFFF), 1'b0, 5);
        do_op(24'h0C0000, 24'h800000, ref_dsig(24'h0C0000), ref_delta(24'h0C0000, 24'h800000), 1'b0, 0);

        // Reset while in MUL_E, with i_valid asserted alongside reset
        ifc.i_valid = 1'b1;
        ifc.i_s     = 24'h080000;
        ifc.i_err   = 24'h100000;
        step();
        ifc.i_valid = 1'b0;
        step();
        rst         = 1'b1;
        ifc.i_valid = 1'b1;
        #1;
        chk("midrst_ird", W'(ifc.i_ready), W'(0));
        step();
        rst         = 1'b0;
        ifc.i_valid = 1'b0;
        #1;
        chk("midrst_vld", W'(ifc.o_valid), W'(0));
        chk("midrst_dsig", ifc.o_dsig, W'(0));
        chk("midrst_delta", ifc.o_delta, W'(0));
        chk("midrst_ird_after", W'(ifc.i_ready), W'(1));
        ifc.o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_out", W'(ifc.o_valid), W'(0));
            chk("midrst_idle", W'(ifc.i_ready), W'(1));
        end
        ifc.o_ready = 1'b0;
        prev_d = '0;
        prev_e = '0;

        // Randomized operands, mixing in-range and out-of-range activations
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0)
                rs = W'($urandom);
            else
                rs = W'($urandom_range(0, 24'h100000));
            re = W'($urandom);
            do_op(rs, re, ref_dsig(rs), ref_delta(rs, re), 1'($urandom_range(0, 1)),
                  (k % 7 == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
